// File: rtl/mc_tag_issuer_if.sv
// rtl/mc_tag_issuer_if.sv - request, tagged-output and retire signals of mc_tag_issuer
// slave is the issuer side; master is the requester/scheduler/returner side.
interface mc_tag_issuer_if #(
    parameter int READ_ENTRIES_LOG  = 6,
    parameter int WRITE_ENTRIES_LOG = 6,
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 16
);
    localparam int IDX_W = (READ_ENTRIES_LOG > WRITE_ENTRIES_LOG) ? READ_ENTRIES_LOG : WRITE_ENTRIES_LOG;

    logic                         rd_req_valid;
    logic                         rd_req_ready;
    logic [ADDR_WIDTH-1:0]        rd_req_addr;
    logic                         wr_req_valid;
    logic                         wr_req_ready;
    logic [ADDR_WIDTH-1:0]        wr_req_addr;
    logic [DATA_WIDTH-1:0]        wr_req_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_type;
    logic [IDX_W-1:0]             out_index;
    logic [ADDR_WIDTH-1:0]        out_addr;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         read_done;
    logic                         write_done;
    logic [READ_ENTRIES_LOG:0]    rd_outstanding;
    logic [WRITE_ENTRIES_LOG:0]   wr_outstanding;
    logic                         err_underflow;

    modport slave (
        input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        input  out_ready, read_done, write_done,
        output rd_req_ready, wr_req_ready, out_valid, out_type, out_index, out_addr, out_data,
        output rd_outstanding, wr_outstanding, err_underflow
    );

    modport master (
        output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        output out_ready, read_done, write_done,
        input  rd_req_ready, wr_req_ready, out_valid, out_type, out_index, out_addr, out_data,
        input  rd_outstanding, wr_outstanding, err_underflow
    );
endinterface

// File: rtl/mc_tag_issuer.sv
// rtl/mc_tag_issuer.sv - read/write arbiter stamping per-type sequential tags, with credit back-pressure
// Define MC_TAG_ISSUER_RR_EN for round-robin arbitration; default is fixed read priority.
module mc_tag_issuer #(
    parameter int READ_ENTRIES_LOG  = 6,
    parameter int WRITE_ENTRIES_LOG = 6,
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_tag_issuer_if.slave    bus
);
    localparam int R     = READ_ENTRIES_LOG;
    localparam int W     = WRITE_ENTRIES_LOG;
    localparam int IDX_W = (R > W) ? R : W;

    localparam logic [R:0] RD_CAP     = {1'b1, {R{1'b0}}};
    localparam logic [W:0] WR_CAP     = {1'b1, {W{1'b0}}};
    localparam logic       TYPE_READ  = 1'b0;
    localparam logic       TYPE_WRITE = 1'b1;

    logic                  out_valid_q, out_valid_d;
    logic                  out_type_q,  out_type_d;
    logic [IDX_W-1:0]      out_index_q, out_index_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [R-1:0]          rd_tag_q,    rd_tag_d;
    logic [W-1:0]          wr_tag_q,    wr_tag_d;
    logic [R:0]            rd_cnt_q,    rd_cnt_d;
    logic [W:0]            wr_cnt_q,    wr_cnt_d;
    logic                  err_q,       err_d;

    logic slot_free, rd_elig, wr_elig, grant_rd, grant_wr, rd_acc, wr_acc;

    // Credits come only from registered counts, so done pulses never reach ready combinationally.
    assign slot_free = !out_valid_q || bus.out_ready;
    assign rd_elig   = bus.rd_req_valid && (rd_cnt_q < RD_CAP);
    assign wr_elig   = bus.wr_req_valid && (wr_cnt_q < WR_CAP);

`ifdef MC_TAG_ISSUER_RR_EN
    typedef enum logic {LAST_RD = 1'b0, LAST_WR = 1'b1} last_e;
    last_e last_q, last_d;

    assign grant_rd = rd_elig && (!wr_elig || (last_q == LAST_WR));

    always_comb begin
        last_d = last_q;
        if (rd_acc) begin
            last_d = LAST_RD;
        end else if (wr_acc) begin
            last_d = LAST_WR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= LAST_WR;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant_rd = rd_elig;
`endif

    assign grant_wr = wr_elig && !grant_rd;
    assign rd_acc   = slot_free && grant_rd;
    assign wr_acc   = slot_free && grant_wr;

    assign bus.rd_req_ready   = rd_acc;
    assign bus.wr_req_ready   = wr_acc;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_type       = out_type_q;
    assign bus.out_index      = out_index_q;
    assign bus.out_addr       = out_addr_q;
    assign bus.out_data       = out_data_q;
    assign bus.rd_outstanding = rd_cnt_q;
    assign bus.wr_outstanding = wr_cnt_q;
    assign bus.err_underflow  = err_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_type_d  = out_type_q;
        out_index_d = out_index_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        rd_tag_d    = rd_tag_q;
        wr_tag_d    = wr_tag_q;

        if (rd_acc) begin
            out_valid_d = 1'b1;
            out_type_d  = TYPE_READ;
            out_index_d = IDX_W'(rd_tag_q);
            out_addr_d  = bus.rd_req_addr;
            out_data_d  = '0;
            rd_tag_d    = rd_tag_q + R'(1);
        end else if (wr_acc) begin
            out_valid_d = 1'b1;
            out_type_d  = TYPE_WRITE;
            out_index_d = IDX_W'(wr_tag_q);
            out_addr_d  = bus.wr_req_addr;
            out_data_d  = bus.wr_req_data;
            wr_tag_d    = wr_tag_q + W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Accept and retire of the same type cancel; a retire at zero saturates and flags underflow.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;

        if (rd_acc && !bus.read_done) begin
            rd_cnt_d = rd_cnt_q + (R+1)'(1);
        end else if (!rd_acc && bus.read_done && (rd_cnt_q != '0)) begin
            rd_cnt_d = rd_cnt_q - (R+1)'(1);
        end

        if (wr_acc && !bus.write_done) begin
            wr_cnt_d = wr_cnt_q + (W+1)'(1);
        end else if (!wr_acc && bus.write_done && (wr_cnt_q != '0)) begin
            wr_cnt_d = wr_cnt_q - (W+1)'(1);
        end

        if ((bus.read_done && (rd_cnt_q == '0)) || (bus.write_done && (wr_cnt_q == '0))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_type_q  <= 1'b0;
            out_index_q <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            rd_tag_q    <= '0;
            wr_tag_q    <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_index_q <= out_index_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            rd_tag_q    <= rd_tag_d;
            wr_tag_q    <= wr_tag_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_mc_tag_issuer.sv
// tb/tb_mc_tag_issuer.sv - scoreboard bench for mc_tag_issuer with a transaction-level reference model
module tb_mc_tag_issuer;
    localparam int RD_LOG  = 6;
    localparam int WR_LOG  = 6;
    localparam int RD_TAGS = 1 << RD_LOG;
    localparam int WR_TAGS = 1 << WR_LOG;

    typedef struct packed {
        logic        typ;
        logic [5:0]  idx;
        logic [31:0] addr;
        logic [15:0] data;
    } item_t;

    logic clk;
    logic rst_n;

    mc_tag_issuer_if #(.READ_ENTRIES_LOG(RD_LOG), .WRITE_ENTRIES_LOG(WR_LOG),
                       .ADDR_WIDTH(32), .DATA_WIDTH(16)) bus ();

    mc_tag_issuer #(.READ_ENTRIES_LOG(RD_LOG), .WRITE_ENTRIES_LOG(WR_LOG),
                    .ADDR_WIDTH(32), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    in_reset = 1'b1;
    item_t sb[$];

    // Reference model: tag counters, in-flight counts, output-slot occupancy, last grant.
    int m_rd_cnt, m_wr_cnt, m_rd_tag, m_wr_tag;
    bit m_held, m_last_wr, m_err;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd_cnt = 0; m_wr_cnt = 0; m_rd_tag = 0; m_wr_tag = 0;
        m_held = 0; m_last_wr = 1; m_err = 0;
    endtask

    task automatic drive_idle();
        bus.rd_req_valid = 0; bus.wr_req_valid = 0; bus.out_ready = 0;
        bus.read_done = 0; bus.write_done = 0;
        bus.rd_req_addr = '0; bus.wr_req_addr = '0; bus.wr_req_data = '0;
    endtask

    task automatic model_step(input bit rv, input bit wv, input bit orr, input bit rdn, input bit wdn,
                              input logic [31:0] ra, input logic [31:0] wa, input logic [15:0] wd);
        bit slot_free, er, ew, gr, gw, ra_acc, wa_acc;
        item_t it;
        slot_free = !m_held || orr;
        er = rv && (m_rd_cnt < RD_TAGS);
        ew = wv && (m_wr_cnt < WR_TAGS);
`ifdef MC_TAG_ISSUER_RR_EN
        gr = er && (!ew || m_last_wr);
`else
        gr = er;
`endif
        gw = ew && !gr;
        ra_acc = slot_free && gr;
        wa_acc = slot_free && gw;
        chk("rd_req_ready", bus.rd_req_ready, ra_acc);
        chk("wr_req_ready", bus.wr_req_ready, wa_acc);
        chk("rd_outstanding", bus.rd_outstanding, m_rd_cnt);
        chk("wr_outstanding", bus.wr_outstanding, m_wr_cnt);
        chk("err_underflow", bus.err_underflow, m_err);

        if (ra_acc) begin
            it.typ = 1'b0; it.idx = 6'(m_rd_tag); it.addr = ra; it.data = 16'h0;
            sb.push_back(it);
            m_rd_tag = (m_rd_tag + 1) % RD_TAGS;
            m_held = 1; m_last_wr = 0;
        end else if (wa_acc) begin
            it.typ = 1'b1; it.idx = 6'(m_wr_tag); it.addr = wa; it.data = wd;
            sb.push_back(it);
            m_wr_tag = (m_wr_tag + 1) % WR_TAGS;
            m_held = 1; m_last_wr = 1;
        end else if (orr) begin
            m_held = 0;
        end

        if ((rdn && m_rd_cnt == 0) || (wdn && m_wr_cnt == 0)) m_err = 1;
        if (ra_acc && !rdn) m_rd_cnt++;
        else if (!ra_acc && rdn && m_rd_cnt > 0) m_rd_cnt--;
        if (wa_acc && !wdn) m_wr_cnt++;
        else if (!wa_acc && wdn && m_wr_cnt > 0) m_wr_cnt--;
    endtask

    task automatic cycle(input bit rv, input bit wv, input bit orr, input bit rdn, input bit wdn,
                         input logic [31:0] ra, input logic [31:0] wa, input logic [15:0] wd);
        @(posedge clk); #1;
        bus.rd_req_valid = rv; bus.wr_req_valid = wv; bus.out_ready = orr;
        bus.read_done = rdn; bus.write_done = wdn;
        bus.rd_req_addr = ra; bus.wr_req_addr = wa; bus.wr_req_data = wd;
        #4;
        model_step(rv, wv, orr, rdn, wdn, ra, wa, wd);
    endtask

    task automatic cyc(input bit rv, input bit wv, input bit orr, input bit rdn, input bit wdn);
        cycle(rv, wv, orr, rdn, wdn, $urandom, $urandom, 16'($urandom));
    endtask

    task automatic do_reset();
        in_reset = 1;
        @(posedge clk); #1;
        rst_n = 0;
        drive_idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        sb.delete();
        model_reset();
        in_reset = 0;
        chk("reset_out_fields", {bus.out_valid, bus.out_type, bus.out_index, bus.out_addr, bus.out_data}, 0);
    endtask

    task automatic rand_cycle();
        bit rdn, wdn;
        rdn = (m_rd_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        wdn = (m_wr_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, rdn, wdn);
    endtask

    // Monitor: checks the output register against the scoreboard head every cycle, pops on handoff.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (!in_reset) begin
                chk("out_valid", bus.out_valid, sb.size() != 0);
                if (sb.size() != 0) begin
                    chk("out_fields", {bus.out_type, bus.out_index, bus.out_addr, bus.out_data}, sb[0]);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 0;
        drive_idle();
        model_reset();
        do_reset();

        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 32'h100 + i, 0, 0);
        cyc(0, 0, 1, 0, 0);

        for (int i = 0; i < 61; i++) cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);

        for (int i = 0; i < 54; i++) cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 80 && m_rd_cnt > 0; i++) cyc(0, 0, 1, 1, 0);

        for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        cycle(0, 1, 1, 0, 0, 0, 32'h40, 16'hBEEF);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        for (int i = 0; i < 200 && (m_rd_cnt > 0 || m_wr_cnt > 0); i++)
            cyc(0, 0, 1, m_rd_cnt > 0, m_wr_cnt > 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        do_reset();
        cyc(0, 0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rand_cycle();
            if (i == 1500) do_reset();
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
